// File: rtl/reg_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_uart
// Purpose  : Sweeps the CPU register-observation index and sends every
//            32-bit register over a UART 8N1 line, MSB byte first.
//            Optional macro REG_DUMP_INDEX_EN prefixes each register with
//            an index byte {3'b000, observe}.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_REGS     = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic [4:0]  observe,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]         c_LAST_REG = 5'(NUM_REGS - 1);
`ifdef REG_DUMP_INDEX_EN
    localparam logic [2:0]         c_LAST_BYTE  = 3'd4;
    localparam logic [2:0]         c_FIRST_DATA = 3'd1;
`else
    localparam logic [2:0]         c_LAST_BYTE  = 3'd3;
    localparam logic [2:0]         c_FIRST_DATA = 3'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LATCH     = 3'd1,
        S_START_BIT = 3'd2,
        S_DATA      = 3'd3,
        S_STOP_BIT  = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         r_byte_cnt;
    logic [31:0]        r_word;
    logic [7:0]         r_shift;

    logic               w_bit_end;
    logic [2:0]         w_data_idx;
    logic [7:0]         w_cur_byte;

    assign w_bit_end  = (r_clk_cnt == c_CNT_LAST);
    assign w_data_idx = r_byte_cnt - c_FIRST_DATA;

    // Byte to be framed next; data bytes leave the latched word MSB first.
    always_comb begin
        w_cur_byte = r_word[31:24];
        case (w_data_idx)
            3'd1:    w_cur_byte = r_word[23:16];
            3'd2:    w_cur_byte = r_word[15:8];
            3'd3:    w_cur_byte = r_word[7:0];
            default: w_cur_byte = r_word[31:24];
        endcase
`ifdef REG_DUMP_INDEX_EN
        if (r_byte_cnt == 3'd0) begin
            w_cur_byte = {3'b000, observe};
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_shift    <= '0;
            observe    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                    r_clk_cnt <= '0;
                    if (start) begin
                        observe <= '0;
                        busy    <= 1'b1;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_word     <= data_in;
                    r_byte_cnt <= '0;
                    r_clk_cnt  <= '0;
                    tx         <= 1'b0;
                    r_state    <= S_START_BIT;
                end
                S_START_BIT: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_shift   <= w_cur_byte;
                        tx        <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            tx      <= 1'b1;
                            r_state <= S_STOP_BIT;
                        end else begin
                            // LSB-first: the next bit is always one position up.
                            tx        <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_STOP_BIT: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_cnt < c_LAST_BYTE) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            tx         <= 1'b0;
                            r_state    <= S_START_BIT;
                        end else if (observe < c_LAST_REG) begin
                            observe <= observe + 1'b1;
                            r_state <= S_LATCH;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_uart
// Purpose  : Randomized bench for reg_dump_uart; decodes the UART line and
//            compares bytes, timing and handshakes against a register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_uart;

    localparam int CPB  = 4;
    localparam int NREG = 32;
`ifdef REG_DUMP_INDEX_EN
    localparam int BPR = 5;
`else
    localparam int BPR = 4;
`endif
    localparam int SPB    = 10 * CPB;
    localparam int RC     = 1 + BPR * SPB;
    localparam int NDUMP  = NREG * RC;
    localparam int NBYTES = NREG * BPR;

    logic        CLK   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_in;
    logic [4:0]  observe;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [NREG];

    int cyc      = 0;
    int done_cnt = 0;
    int n_checks = 0;
    int n_errors = 0;

    assign data_in = regs[observe];

    reg_dump_uart #(
        .CLKS_PER_BIT (CPB),
        .NUM_REGS     (NREG)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .observe (observe),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Byte b of the dump stream, straight from the register model.
    function automatic logic [7:0] exp_byte(input int b);
        int          r;
        int          j;
        logic [31:0] w;
        r = b / BPR;
        j = b % BPR;
        w = regs[r];
`ifdef REG_DUMP_INDEX_EN
        if (j == 0) return 8'(r);
        j = j - 1;
`endif
        return 8'(w >> (24 - 8 * j));
    endfunction

    task automatic launch(input bit hold, output int t_lat);
        @(negedge CLK);
        start = 1'b1;
        t_lat = cyc + 1;
        if (!hold) begin
            @(negedge CLK);
            start = 1'b0;
        end
    endtask

    task automatic collect_dump(input int t_lat, input bit inject);
        logic [SPB-1:0] smp;
        logic [7:0]     got;
        logic [4:0]     obs;
        bit             ok;
        bit             busy_ok;
        int             n;
        int             t0;
        int             r;
        int             j;
        for (int b = 0; b < NBYTES; b++) begin
            r = b / BPR;
            j = b % BPR;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (tx !== 1'b0 && n < 3 * SPB);
            if (tx !== 1'b0) begin
                check_eq("start_bit_seen", {31'b0, tx}, 32'd0);
                return;
            end
            t0      = cyc;
            obs     = observe;
            smp[0]  = tx;
            busy_ok = (busy === 1'b1);
            for (int i = 1; i < SPB; i++) begin
                @(negedge CLK);
                smp[i] = tx;
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (inject && (b == 3 || b == 41 || b == 100)) begin
                    if (i == 5) start = 1'b1;
                    else if (i == 6) start = 1'b0;
                end
            end
            ok  = (smp[0] === 1'b0) && (smp[9 * CPB] === 1'b1);
            got = '0;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (smp[k * CPB + c] !== smp[k * CPB]) ok = 1'b0;
                end
                if (k >= 1 && k <= 8) got[k - 1] = smp[k * CPB];
            end
            check_eq("byte", {24'b0, got}, {24'b0, exp_byte(b)});
            check_eq("frame", {31'b0, ok}, 32'd1);
            check_eq("observe", {27'b0, obs}, 32'(r));
            check_eq("byte_start_cyc", 32'(t0 - t_lat), 32'(r * RC + 1 + j * SPB));
            check_eq("busy_in_frame", {31'b0, busy_ok}, 32'd1);
        end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (done !== 1'b1 && n < 4 * SPB);
        check_eq("done_seen", {31'b0, done}, 32'd1);
        check_eq("done_latency", 32'(cyc - t_lat), 32'(NDUMP));
        check_eq("busy_at_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int  t_lat;
        int  dc0;
        int  n;
        bit  stable;

        for (int r = 0; r < NREG; r++) regs[r] = $urandom;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_observe", {27'b0, observe}, 32'd0);
        reset = 1'b0;

        stable = 1'b1;
        repeat (100) begin
            @(negedge CLK);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || observe !== 5'd0) stable = 1'b0;
        end
        check_eq("idle_hold", {31'b0, stable}, 32'd1);

        // Random registers with a known pattern in register 0.
        regs[0] = 32'h1234_5678;
        dc0 = done_cnt;
        launch(1'b0, t_lat);
        collect_dump(t_lat, 1'b0);
        @(negedge CLK);
        check_eq("done_one_cycle", {31'b0, done}, 32'd0);
        repeat (2) @(negedge CLK);
        check_eq("done_pulses_a", 32'(done_cnt - dc0), 32'd1);

        // Ramp pattern with start pulses injected while busy.
        for (int r = 0; r < NREG; r++) regs[r] = 32'(r) * 32'h0101_0101;
        dc0 = done_cnt;
        launch(1'b0, t_lat);
        collect_dump(t_lat, 1'b1);
        repeat (3) @(negedge CLK);
        check_eq("done_pulses_b", 32'(done_cnt - dc0), 32'd1);
        check_eq("idle_after_b", {31'b0, busy}, 32'd0);

        // start held high through completion restarts immediately.
        for (int r = 0; r < NREG; r++) regs[r] = $urandom;
        regs[5][31:24] = 8'h00;
        launch(1'b1, t_lat);
        collect_dump(t_lat, 1'b0);
        @(negedge CLK);
        check_eq("restart_busy", {31'b0, busy}, 32'd1);
        check_eq("restart_observe", {27'b0, observe}, 32'd0);
        check_eq("restart_done", {31'b0, done}, 32'd0);
        start = 1'b0;

        // Reset while bit 3 of register 5's first byte is on the line.
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (observe !== 5'd5 && n < 7 * RC);
        check_eq("reach_reg5", {27'b0, observe}, 32'd5);
        repeat (1 + 4 * CPB) @(negedge CLK);
        check_eq("pre_reset_tx", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge CLK);
        check_eq("midrst_tx", {31'b0, tx}, 32'd1);
        check_eq("midrst_observe", {27'b0, observe}, 32'd0);
        check_eq("midrst_busy", {31'b0, busy}, 32'd0);
        check_eq("midrst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        for (int r = 0; r < NREG; r++) regs[r] = $urandom;
        dc0 = done_cnt;
        launch(1'b0, t_lat);
        collect_dump(t_lat, 1'b0);
        repeat (3) @(negedge CLK);
        check_eq("done_pulses_d", 32'(done_cnt - dc0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
